// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - decode stage: register file, operand fetch with writeback bypass, load-use stall
// Optional feature macro: R0_ZERO_EN (R0 hardwired to zero)
module instr_decode #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        if_id_reg,
    input  logic              if_id_valid,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_out,
    output logic              id_ex_valid,
    output logic [1:0]        id_ex_op,
    output logic [2:0]        id_ex_rd,
    output logic [DATA_W-1:0] id_ex_a,
    output logic [DATA_W-1:0] id_ex_b
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_MOVI = 2'b11;

    logic [DATA_W-1:0] regs [NREGS];

    logic [1:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic              reads_rd;
    logic              reads_rs;
    logic              hazard;
    logic              wr_ok;

    assign op = if_id_reg[7:6];
    assign rd = if_id_reg[5:3];
    assign rs = if_id_reg[2:0];

`ifdef R0_ZERO_EN
    assign wr_ok = wb_en && (wb_addr != 3'd0);
`else
    assign wr_ok = wb_en;
`endif

    // Same-cycle writeback bypass; wr_ok already excludes R0 when it is hardwired
    always_comb begin
        rd_val = regs[rd];
        rs_val = regs[rs];
        if (wr_ok && wb_addr == rd) rd_val = wb_data;
        if (wr_ok && wb_addr == rs) rs_val = wb_data;
`ifdef R0_ZERO_EN
        if (rd == 3'd0) rd_val = '0;
        if (rs == 3'd0) rs_val = '0;
`endif
    end

    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        reads_rd = 1'b0;
        reads_rs = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                dec_a    = rd_val;
                dec_b    = rs_val;
                reads_rd = 1'b1;
                reads_rs = 1'b1;
            end
            OP_LOAD: begin
                dec_a    = rs_val;
                reads_rs = 1'b1;
            end
            default: dec_b = {{(DATA_W-3){1'b0}}, rs};
        endcase
    end

    always_comb begin
        hazard = id_ex_valid && (id_ex_op == OP_LOAD) && if_id_valid && !flush &&
                 ((reads_rd && rd == id_ex_rd) || (reads_rs && rs == id_ex_rd));
`ifdef R0_ZERO_EN
        if (id_ex_rd == 3'd0) hazard = 1'b0;
`endif
    end

    assign stall_out = !reset && (ex_stall || hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || (!ex_stall && hazard)) begin
            id_ex_valid <= 1'b0;
            id_ex_op    <= '0;
            id_ex_rd    <= '0;
            id_ex_a     <= '0;
            id_ex_b     <= '0;
        end else if (!ex_stall) begin
            id_ex_valid <= if_id_valid;
            id_ex_op    <= if_id_valid ? op    : 2'b00;
            id_ex_rd    <= if_id_valid ? rd    : 3'd0;
            id_ex_a     <= if_id_valid ? dec_a : '0;
            id_ex_b     <= if_id_valid ? dec_b : '0;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - directed self-checking bench for instr_decode
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  if_id_reg;
    logic        if_id_valid;
    logic        ex_stall;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_out;
    logic        id_ex_valid;
    logic [1:0]  id_ex_op;
    logic [2:0]  id_ex_rd;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;

    int errors = 0;
    int checks = 0;

    instr_decode dut (
        .clk(clk), .reset(reset), .if_id_reg(if_id_reg), .if_id_valid(if_id_valid),
        .ex_stall(ex_stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall_out(stall_out), .id_ex_valid(id_ex_valid),
        .id_ex_op(id_ex_op), .id_ex_rd(id_ex_rd), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idex(input string tag, input logic v, input logic [1:0] op,
                              input logic [2:0] rd, input logic [31:0] a, input logic [31:0] b);
        check({tag, ".valid"}, {31'b0, id_ex_valid}, {31'b0, v});
        check({tag, ".op"}, {30'b0, id_ex_op}, {30'b0, op});
        check({tag, ".rd"}, {29'b0, id_ex_rd}, {29'b0, rd});
        check({tag, ".a"}, id_ex_a, a);
        check({tag, ".b"}, id_ex_b, b);
    endtask

    initial begin
        // Reset with garbage on every input
        reset = 1; if_id_reg = 8'hFF; if_id_valid = 1; ex_stall = 1; flush = 0;
        wb_en = 1; wb_addr = 3'd2; wb_data = 32'hDEAD_BEEF;
        #1 check("rst_stall", {31'b0, stall_out}, 32'd0);
        step();
        step();
        check_idex("rst", 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        check("rst_stall2", {31'b0, stall_out}, 32'd0);

        reset = 0; if_id_reg = 8'h00; if_id_valid = 0; ex_stall = 0; wb_en = 0;
        step();
        check("idle_valid", {31'b0, id_ex_valid}, 32'd0);
        check("idle_stall", {31'b0, stall_out}, 32'd0);

        // First decode after reset sees zeroed registers (ADD R1,R1) while writing R2=5
        if_id_reg = 8'b00_001_001; if_id_valid = 1; wb_en = 1; wb_addr = 3'd2; wb_data = 32'd5;
        step();
        check_idex("add_r1", 1'b1, 2'd0, 3'd1, 32'd0, 32'd0);
        if_id_valid = 0; wb_addr = 3'd3; wb_data = 32'd7;
        step();
        wb_en = 0; if_id_reg = 8'b00_010_011; if_id_valid = 1;
        step();
        check_idex("add", 1'b1, 2'd0, 3'd2, 32'd5, 32'd7);

        // Bypass on R3
        wb_en = 1; wb_addr = 3'd3; wb_data = 32'd100;
        step();
        check_idex("bypass", 1'b1, 2'd0, 3'd2, 32'd5, 32'd100);
        wb_en = 0; if_id_reg = 8'b00_011_011;
        step();
        check_idex("r3_after", 1'b1, 2'd0, 3'd3, 32'd100, 32'd100);

        // Load-use: LOAD R4,[R1] then ADD R4,R2
        if_id_reg = 8'b10_100_001;
        #1 check("load_nostall", {31'b0, stall_out}, 32'd0);
        step();
        check_idex("load", 1'b1, 2'd2, 3'd4, 32'd0, 32'd0);
        if_id_reg = 8'b00_100_010;
        #1 check("lu_stall", {31'b0, stall_out}, 32'd1);
        step();
        check_idex("lu_bubble", 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        check("lu_stall_clr", {31'b0, stall_out}, 32'd0);
        step();
        check_idex("lu_add", 1'b1, 2'd0, 3'd4, 32'd0, 32'd5);

        // ex_stall holds SUB R2,R3 for 3 cycles
        if_id_reg = 8'b01_010_011;
        step();
        check_idex("sub", 1'b1, 2'd1, 3'd2, 32'd5, 32'd100);
        ex_stall = 1; if_id_reg = 8'b11_101_110;
        for (int i = 0; i < 3; i++) begin
            #1 check("exs_stall", {31'b0, stall_out}, 32'd1);
            step();
            check_idex("exs_hold", 1'b1, 2'd1, 3'd2, 32'd5, 32'd100);
        end
        ex_stall = 0;
        step();
        check_idex("movi", 1'b1, 2'd3, 3'd5, 32'd0, 32'd6);

        // Flush and ex_stall together: flush wins
        flush = 1; ex_stall = 1; if_id_reg = 8'b00_010_011;
        #1 check("fl_stall", {31'b0, stall_out}, 32'd1);
        step();
        check_idex("flush", 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        flush = 0; ex_stall = 0;

        // LOAD R0 then ADD R0,R1
        if_id_reg = 8'b10_000_001;
        step();
        if_id_reg = 8'b00_000_001;
`ifdef R0_ZERO_EN
        #1 check("r0_nostall", {31'b0, stall_out}, 32'd0);
        step();
        check("r0_valid", {31'b0, id_ex_valid}, 32'd1);
`else
        #1 check("r0_stall", {31'b0, stall_out}, 32'd1);
        step();
        check("r0_bubble", {31'b0, id_ex_valid}, 32'd0);
`endif

        // Reset in the middle of a stall clears registers and ID/EX
        ex_stall = 1; reset = 1;
        #1 check("mid_rst_stall", {31'b0, stall_out}, 32'd0);
        step();
        check_idex("mid_rst", 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
        reset = 0; ex_stall = 0; if_id_reg = 8'b00_010_011;
        step();
        check_idex("post_rst", 1'b1, 2'd0, 3'd2, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
